timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 36 +++
 rtl/timer_channel.sv | 109 ++++++++++
 rtl/timer_bank.sv | 92 +++++++++
 tb/tb_timer_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: FSM states, register map, CTRL layout.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_t;

  // Word index of each register inside a 16-byte channel slot
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL field positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;
  localparam int unsigned CTRL_PSC_LSB  = 4;

  // MODE codes; anything other than MODE_AUTO runs one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  // Decode window: 16 channel slots, so the slot after the last channel of a
  // full 8-channel bank still decodes as an in-window (erroring) access
  localparam logic [31:0] WIN_BYTES = 32'h0000_0100;

  // Terminal value of the prescaler counter for a given PSC
  function automatic logic [15:0] psc_mask(input logic [3:0] psc);
    return (16'd1 << psc) - 16'd1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and FSM.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ctrl_we,
  input  logic             i_preset_we,
  input  logic             i_status_we,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [7:0]       o_ctrl,
  output logic [CNT_W-1:0] o_preset,
  output logic [CNT_W-1:0] o_count,
  output logic             o_pend,
  output logic             o_irq
);

  tmr_state_t       r_state;
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [3:0]       r_psc;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;
  logic [15:0]      r_psc_cnt;

  logic             w_tick;

  assign w_tick = (r_psc_cnt == psc_mask(r_psc));

  // Registers and channel FSM; a CTRL write overrides the FSM's own next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_en      <= 1'b0;
      r_mode    <= MODE_ONESHOT;
      r_im      <= 1'b0;
      r_psc     <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pend    <= 1'b0;
      r_psc_cnt <= '0;
    end else begin
      if (i_preset_we) begin
        r_preset <= i_wdata;
      end

      // INT sets PEND even when a clear lands in the same cycle
      if (r_state == ST_INT) begin
        r_pend <= 1'b1;
      end else if (i_status_we && i_wdata[0]) begin
        r_pend <= 1'b0;
      end

      if (i_ctrl_we) begin
        r_en    <= i_wdata[CTRL_EN_BIT];
        r_mode  <= i_wdata[CTRL_MODE_LSB +: 2];
        r_im    <= i_wdata[CTRL_IM_BIT];
        r_psc   <= i_wdata[CTRL_PSC_LSB +: 4];
        r_state <= i_wdata[CTRL_EN_BIT] ? ST_LOAD : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_LOAD: begin
            r_count   <= r_preset;
            r_psc_cnt <= '0;
            r_state   <= ST_CNT;
          end
          ST_CNT: begin
            if (w_tick) begin
              r_psc_cnt <= '0;
              if (r_count <= CNT_W'(1)) begin
                r_count <= '0;
                r_state <= ST_INT;
              end else begin
                r_count <= r_count - CNT_W'(1);
              end
            end else begin
              r_psc_cnt <= r_psc_cnt + 16'd1;
            end
          end
          ST_INT: begin
            if (r_mode == MODE_AUTO) begin
              r_state <= ST_LOAD;
            end else begin
              r_en    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ctrl   = {r_psc, r_im, r_mode, r_en};
  assign o_preset = r_preset;
  assign o_count  = r_count;
  assign o_pend   = r_pend;
  assign o_irq    = r_pend & r_im;

endmodule

// File: rtl/timer_bank.sv
// Timer bank top: bus decode, error detection, read mux, NUM_CH channels.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [31:0] w_off;
  logic        w_in_win;
  logic [3:0]  w_ch;
  logic [1:0]  w_reg;
  logic        w_ch_ok;
  logic        w_bad;
  logic        w_wr_ok;
  logic [31:0] w_rd_word [NUM_CH];
  logic        w_unused_wdata;

  assign w_off    = addr - BASE_ADDR;
  assign w_in_win = (addr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_ch     = w_off[7:4];
  assign w_reg    = w_off[3:2];
  assign w_ch_ok  = (32'(w_ch) < NUM_CH);

  assign w_bad = (be != 4'b1111) || (addr[1:0] != 2'b00) || !w_ch_ok ||
                 (we && (w_reg == REG_COUNT));

  assign err     = (we || re) && w_in_win && w_bad;
  assign w_wr_ok = we && w_in_win && !w_bad;

  // Upper write-data bits beyond CNT_W only matter for CTRL, which uses [7:0]
  assign w_unused_wdata = ^wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             w_sel;
    logic [7:0]       w_ctrl;
    logic [CNT_W-1:0] w_preset;
    logic [CNT_W-1:0] w_count;
    logic             w_pend;

    assign w_sel = w_wr_ok && (w_ch == 4'(g));

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_ctrl_we  (w_sel && (w_reg == REG_CTRL)),
      .i_preset_we(w_sel && (w_reg == REG_PRESET)),
      .i_status_we(w_sel && (w_reg == REG_STATUS)),
      .i_wdata    (wdata[CNT_W-1:0]),
      .o_ctrl     (w_ctrl),
      .o_preset   (w_preset),
      .o_count    (w_count),
      .o_pend     (w_pend),
      .o_irq      (irq[g])
    );

    assign w_rd_word[g] = (w_reg == REG_CTRL)   ? 32'(w_ctrl)   :
                          (w_reg == REG_PRESET) ? 32'(w_preset) :
                          (w_reg == REG_COUNT)  ? 32'(w_count)  :
                                                  32'(w_pend);
  end

  // Read mux: zero outside the window or past the last channel
  always_comb begin
    rdata = '0;
    if (w_in_win) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_ch == 4'(i)) begin
          rdata = w_rd_word[i];
        end
      end
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: vector table plus multi-cycle sequences.
module tb_timer_bank;

  localparam logic [31:0] BA = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] rdata_a, rdata_b;
  logic        err_a, err_b;
  logic [1:0]  irq_a;
  logic [3:0]  irq_b;
  logic        any_a, any_b;

  int unsigned n_chk;
  int unsigned n_fail;

  typedef enum int {S_RD_A, S_ERR_A, S_IRQ_A, S_ANY_A, S_RD_B, S_IRQ_B, S_ANY_B} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        w;
    logic        r;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];

  timer_bank #(
    .NUM_CH(2), .CNT_W(32), .BASE_ADDR(BA)
  ) u_dut_a (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .be(be), .rdata(rdata_a), .err(err_a), .irq(irq_a), .irq_any(any_a)
  );

  timer_bank #(
    .NUM_CH(4), .CNT_W(8), .BASE_ADDR(BA)
  ) u_dut_b (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .be(be), .rdata(rdata_b), .err(err_b), .irq(irq_b), .irq_any(any_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_v(input string n, input sel_t s, input logic [31:0] v);
    sb_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic add(input string n, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic w, input logic r,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = n; v.a = a; v.d = d; v.b = b; v.w = w; v.r = r;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic w, input logic r);
    @(negedge clk);
    addr = a; wdata = d; be = b; we = w; re = r;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(a, 32'h0, 4'hF, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] ra(input int unsigned ch, input int unsigned off);
    return BA + 32'(16 * ch + off);
  endfunction

  // Scoreboard: everything queued for this cycle is compared mid-low-phase
  always @(negedge clk) begin : mon
    sb_t         e;
    logic [31:0] act;
    #4;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        S_RD_A:  act = rdata_a;
        S_ERR_A: act = 32'(err_a);
        S_IRQ_A: act = 32'(irq_a);
        S_ANY_A: act = 32'(any_a);
        S_RD_B:  act = rdata_b;
        S_IRQ_B: act = 32'(irq_b);
        default: act = 32'(any_b);
      endcase
      check(e.name, act, e.exp);
    end
  end

  initial begin
    logic       p;
    logic       clr;
    logic [3:0] eb;

    n_chk = 0; n_fail = 0;
    reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; be = 4'hF;

    // Reset state
    idle();
    expect_v("rst_irq_a", S_IRQ_A, 0);
    expect_v("rst_any_a", S_ANY_A, 0);
    expect_v("rst_irq_b", S_IRQ_B, 0);
    idle();
    reset = 1'b1;

    // Register access and error vectors on the 2-channel bank
    add("rd_ctrl0_rst",   ra(0, 0),  0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("rd_preset0_rst", ra(0, 4),  0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("rd_count0_rst",  ra(0, 8),  0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("rd_status0_rst", ra(0, 12), 0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("wr_preset0",     ra(0, 4),  32'h12345678, 4'hF, 1, 0, 0, 32'h0,        0);
    add("rd_preset0",     ra(0, 4),  0,            4'hF, 0, 1, 1, 32'h12345678, 0);
    add("wr_count_err",   ra(0, 8),  32'hAA,       4'hF, 1, 0, 0, 32'h0,        1);
    add("rd_count_kept",  ra(0, 8),  0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("wr_be_err",      ra(0, 4),  32'h0,        4'h3, 1, 0, 0, 32'h0,        1);
    add("rd_preset_kept", ra(0, 4),  0,            4'hF, 0, 1, 1, 32'h12345678, 0);
    add("rd_misalign",    ra(0, 2),  0,            4'hF, 0, 1, 0, 32'h0,        1);
    add("wr_past_last",   ra(2, 0),  32'h0,        4'hF, 1, 0, 0, 32'h0,        1);
    add("rd_past_last",   ra(2, 0),  0,            4'hF, 0, 1, 0, 32'h0,        1);
    add("rd_outside",     32'h1000,  0,            4'hF, 0, 1, 1, 32'h0,        0);
    add("wr_ctrl1",       ra(1, 0),  32'hFFFFFF5E, 4'hF, 1, 0, 0, 32'h0,        0);
    add("rd_ctrl1",       ra(1, 0),  0,            4'hF, 0, 1, 1, 32'h5E,       0);
    add("wr_outside",     BA + 32'h100, 32'h1,     4'hF, 1, 0, 0, 32'h0,        0);
    add("rd_be0_err",     ra(1, 0),  0,            4'h0, 0, 1, 0, 32'h0,        1);
    add("no_strobe",      ra(0, 2),  0,            4'h0, 0, 0, 0, 32'h0,        0);
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].w, tbl[i].r);
      expect_v({tbl[i].name, "_err"}, S_ERR_A, 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) expect_v(tbl[i].name, S_RD_A, tbl[i].exp_rd);
    end

    // One-shot, PRESET=3, PSC=0, IM=1 on channel 0
    wr(ra(0, 4), 32'd3);
    wr(ra(0, 0), 32'h9);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 5) begin
        rd(ra(0, 8));
        expect_v($sformatf("os_count_c%0d", c), S_RD_A,
                 (c == 1 || c == 5) ? 32'd0 : 32'(5 - c));
      end else if (c == 6) begin
        rd(ra(0, 0));
        expect_v("os_ctrl_en_clr", S_RD_A, 32'h8);
      end else if (c == 7) begin
        rd(ra(0, 12));
        expect_v("os_pend", S_RD_A, 32'd1);
      end else if (c == 8) begin
        wr(ra(0, 12), 32'd1);
      end else begin
        rd(ra(0, 12));
        expect_v("os_pend_clr", S_RD_A, 32'd0);
      end
      expect_v($sformatf("os_irq_c%0d", c), S_IRQ_A, (c >= 6 && c <= 8) ? 32'd1 : 32'd0);
      expect_v($sformatf("os_any_c%0d", c), S_ANY_A, (c >= 6 && c <= 8) ? 32'd1 : 32'd0);
    end

    // Auto-reload, PRESET=2, PSC=2 on channel 1: INT every 10 cycles
    wr(ra(1, 4), 32'd2);
    wr(ra(1, 0), 32'h2B);
    p = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      clr = (c == 12 || c == 22 || c == 30);
      if (clr) wr(ra(1, 12), 32'd1);
      else begin
        rd(ra(1, 12));
        expect_v($sformatf("ar_status_c%0d", c), S_RD_A, 32'(p));
      end
      expect_v($sformatf("ar_irq_c%0d", c), S_IRQ_A, {30'd0, p, 1'b0});
      if (c % 10 == 0) p = 1'b1;
      else if (clr)    p = 1'b0;
    end
    wr(ra(1, 0), 32'h0);
    wr(ra(1, 12), 32'd1);
    idle();
    expect_v("ar_stopped_irq", S_IRQ_A, 32'd0);

    // 4-channel, 8-bit bank: channel 3 auto-reload alongside channel 0 one-shot
    wr(ra(3, 4), 32'h1FF);
    rd(ra(3, 4));
    expect_v("b_preset3_trunc", S_RD_B, 32'hFF);
    expect_v("a_ch3_err", S_ERR_A, 32'd1);
    for (int c = 0; c <= 262; c++) begin
      if (c == 0)       wr(ra(3, 0), 32'hB);
      else if (c == 1)  wr(ra(0, 0), 32'h9);
      else if (c == 10) wr(ra(0, 12), 32'd1);
      else begin
        rd(ra(3, 8));
        if (c <= 256) expect_v($sformatf("b_count3_c%0d", c), S_RD_B, 32'(257 - c));
      end
      eb = {c >= 258, 2'b00, (c >= 7 && c <= 10)};
      expect_v($sformatf("b_irq_c%0d", c), S_IRQ_B, 32'(eb));
      expect_v($sformatf("b_any_c%0d", c), S_ANY_B, 32'(|eb));
    end
    wr(ra(3, 0), 32'h0);
    wr(ra(3, 12), 32'd1);
    idle();
    expect_v("b_stopped_irq", S_IRQ_B, 32'd0);

    // Reset mid-count with COUNT=5; channel 1 has PRESET=0 and pends early
    wr(ra(0, 4), 32'd8);
    wr(ra(1, 4), 32'd0);
    wr(ra(1, 0), 32'h9);
    wr(ra(0, 0), 32'h9);
    for (int c = 4; c <= 8; c++) begin
      rd(ra(0, 8));
      expect_v($sformatf("rm_count_c%0d", c), S_RD_A, (c == 4) ? 32'd0 : 32'(13 - c));
      expect_v($sformatf("rm_irq_c%0d", c), S_IRQ_A, (c >= 6) ? 32'd2 : 32'd0);
    end
    #6 reset = 1'b0;
    #2;
    check("rst_async_count", rdata_a, 32'd0);
    check("rst_async_irq_a", 32'(irq_a), 32'd0);
    check("rst_async_any_a", 32'(any_a), 32'd0);
    check("rst_async_irq_b", 32'(irq_b), 32'd0);
    idle();
    expect_v("rst_hold_irq", S_IRQ_A, 32'd0);
    idle();
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      rd(ra(0, (c % 2 == 1) ? 8 : 0));
      expect_v($sformatf("post_rst_rd_c%0d", c), S_RD_A, 32'd0);
      expect_v($sformatf("post_rst_irq_c%0d", c), S_IRQ_A, 32'd0);
    end
    wr(ra(0, 0), 32'h9);
    for (int c = 1; c <= 5; c++) begin
      rd(ra(0, 12));
      expect_v($sformatf("restart_pend_c%0d", c), S_RD_A, (c >= 4) ? 32'd1 : 32'd0);
      expect_v($sformatf("restart_irq_c%0d", c), S_IRQ_A, (c >= 4) ? 32'd1 : 32'd0);
    end

    idle();
    @(negedge clk);
    #6;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
